// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Types and constants shared by the UART receiver and transmitter.
//   Contents:
//     UART_DATA_BITS   - default data bits per frame
//     UART_OVERSAMPLE  - default enable ticks per bit period
//     rx_state_t       - receiver frame-tracking states
//     majority3()      - 2-of-3 vote used by the optional noise filter
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//   N-stage synchronizer for an asynchronous input. All stages reset to 1,
//   which is the idle level of a UART line, so a reset never looks like a
//   start bit.
//   Parameters:
//     STAGES  - number of flops in the chain (>= 1)
//   Ports:
//     clk     in   system clock
//     reset   in   synchronous, active-high reset
//     d       in   asynchronous input
//     q       out  synchronized output (last stage)
// -----------------------------------------------------------------------------
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   UART receive stage: 1 start bit, DATA_BITS data bits, 1 stop bit, sampled
//   with an oversample tick from the shared baud-rate generator. Each byte is
//   presented with RDA until the bus side acknowledges it; framing and overrun
//   errors are flagged alongside.
//
//   Build option:
//     RX_MAJORITY_VOTE_EN - when defined, every bit (start, data, stop) is the
//                           2-of-3 majority of the ticks mid-1, mid, mid+1; the
//                           decision lands one tick later than the plain build.
//
//   Parameters:
//     DATA_BITS    - data bits per frame
//     OVERSAMPLE   - enable ticks per bit period (even, >= 4)
//     MSB_FIRST    - 1: first received data bit is bit DATA_BITS-1; 0: LSB first
//     SYNC_STAGES  - flops in the RxD synchronizer
//   Ports:
//     clk            in   system clock
//     reset          in   synchronous, active-high reset
//     enable         in   oversample tick, one clk wide
//     RxD            in   asynchronous serial line, idles high
//     read_ack       in   bus side has consumed rx_data
//     rx_data        out  last received byte
//     RDA            out  receive data available
//     framing_error  out  stop bit of the current byte was sampled low
//     overrun        out  a byte was overwritten before read_ack
//     busy           out  frame reception in progress
// -----------------------------------------------------------------------------
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = UART_DATA_BITS,
   parameter int OVERSAMPLE  = UART_OVERSAMPLE,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 RxD,
   input  logic                 read_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 RDA,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS + 1);

`ifdef RX_MAJORITY_VOTE_EN
   localparam int VOTE_DLY = 1;
`else
   localparam int VOTE_DLY = 0;
`endif

   // Start bit is judged at its middle; afterwards every OVERSAMPLE ticks lands
   // mid-bit again. The vote build shifts the whole grid by one tick.
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(OVERSAMPLE / 2 - 1 + VOTE_DLY);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_BITS - 1);

   logic rxs;
   logic bit_val;

   rx_state_t            state_q,    state_d;
   logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
   logic                 rda_q,      rda_d;
   logic                 fe_q,       fe_d;
   logic                 ovr_q,      ovr_d;
   logic                 busy_q,     busy_d;
   logic                 deliver;
   logic                 fe_next;

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_rxd_sync (
      .clk   (clk),
      .reset (reset),
      .d     (RxD),
      .q     (rxs)
   );

`ifdef RX_MAJORITY_VOTE_EN
   // Last two tick samples of rxs; together with the current one they form
   // the mid-1 / mid / mid+1 window at the decision tick.
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if (enable) begin
         hist_d = {hist_q[0], rxs};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign bit_val = majority3(hist_q[1], hist_q[0], rxs);
`else
   assign bit_val = rxs;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rda_d      = rda_q;
      fe_d       = fe_q;
      ovr_d      = ovr_q;
      deliver    = 1'b0;
      fe_next    = 1'b0;

      if (enable) begin
         unique case (state_q)
            IDLE: begin
               if (!rxs) begin
                  state_d    = START;
                  tick_cnt_d = '0;
               end
            end
            START: begin
               if (tick_cnt_q == START_LAST) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  // A line that is high again by mid-bit was only a glitch.
                  state_d    = bit_val ? IDLE : DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (tick_cnt_q == BIT_LAST) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                  if (MSB_FIRST != 0) begin
                     shift_d = {shift_q[DATA_BITS-2:0], bit_val};
                  end else begin
                     shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                  end
                  if (bit_cnt_q == LAST_DATA) begin
                     state_d = STOP;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (tick_cnt_q == BIT_LAST) begin
                  tick_cnt_d = '0;
                  deliver    = 1'b1;
                  fe_next    = ~bit_val;
                  // A low stop bit parks in BREAK so a held-low line cannot
                  // start a fresh frame.
                  state_d    = bit_val ? IDLE : BREAK;
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
            BREAK: begin
               if (rxs) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // A delivery outranks a coincident acknowledge: the new byte is unread.
      if (deliver) begin
         rx_data_d = shift_q;
         rda_d     = 1'b1;
         fe_d      = fe_next;
         ovr_d     = rda_q & ~read_ack;
      end else if (read_ack && rda_q) begin
         rda_d = 1'b0;
         fe_d  = 1'b0;
         ovr_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rda_q      <= 1'b0;
         fe_q       <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rda_q      <= rda_d;
         fe_q       <= fe_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign RDA           = rda_q;
   assign framing_error = fe_q;
   assign overrun       = ovr_q;
   assign busy          = busy_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage, the counterpart of the team's transmitter on the far end of the serial line. It samples RxD using a 16x oversample tick from the shared baud-rate generator and reassembles 8-bit frames: 1 start bit, 8 data bits, 1 stop bit. It presents each byte to the data-bus side with a Receive-Data-Available (RDA) flag that the bus side clears with a read acknowledge. It also reports framing and overrun errors.

Parameters:
DATA_BITS, 8, data bits per frame.
OVERSAMPLE, 16, enable ticks per bit period; must be even and >= 4.
MSB_FIRST, 1, 1 = first data bit received is bit DATA_BITS-1; 0 = LSB first.
SYNC_STAGES, 2, flops in the RxD synchronizer.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  oversample tick; one clk-wide pulse, OVERSAMPLE pulses per bit period.
RxD  input  1  asynchronous serial line; idles high.
read_ack  input  1  one-cycle pulse; bus side has consumed rx_data.
rx_data  output  DATA_BITS  last received byte.
RDA  output  1  receive data available.
framing_error  output  1  stop bit of the current byte was sampled low.
overrun  output  1  a byte was overwritten before read_ack.
busy  output  1  frame reception in progress (state != IDLE).

Behaviour:
- Reset values: rx_data=0, RDA=0, framing_error=0, overrun=0, busy=0. Synchronizer flops reset to 1. State=IDLE. Tick counter and bit counter reset to 0.
- Reset mid-frame aborts the frame. No partial data is delivered.
- Only the synchronized line (rxs) is used internally. All sampling logic advances only on cycles with enable=1.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on the first tick with rxs=0, go to START and clear the tick counter.
- START: count ticks up to OVERSAMPLE/2-1 (the mid-bit point).
  - If rxs=1 at the mid-bit point, it was a false start; return to IDLE.
  - Otherwise go to DATA with the tick counter cleared and bit counter=0.
- DATA: sample on every OVERSAMPLE-th tick, which is mid-bit.
  - Each sample is shifted into the shift register in the MSB_FIRST order.
  - After DATA_BITS samples, go to STOP.
- STOP: sample after OVERSAMPLE ticks.
  - If rxs=1: framing_error_next=0; go to IDLE.
  - If rxs=0: framing_error_next=1; go to BREAK.
  - In both cases the byte is delivered.
- BREAK: wait for the first tick with rxs=1, then go to IDLE. This prevents a held-low line from re-triggering reception.
- Delivery happens on the clk edge that ends STOP (one clk after the stop-sample tick):
  - rx_data loads the shift register, RDA<=1, framing_error<=framing_error_next.
  - overrun<=1 if RDA was already 1 and read_ack is not asserted on that cycle.
- read_ack with no delivery on the same cycle: RDA<=0, framing_error<=0, overrun<=0. rx_data holds its value.
- read_ack coincident with a delivery: the new byte wins, RDA stays 1, overrun stays 0.
- read_ack while RDA=0 has no effect.
- Latency: RDA rises SYNC_STAGES + 1 clk after the stop-bit mid-sample tick, referenced to the RxD edges.
- enable held high continuously is legal; it yields one sample step per clk.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined: each bit value (including start and stop) is the 2-of-3 majority of rxs at ticks mid-1, mid and mid+1. The decision takes effect at tick mid+1, so every transition is delayed by one tick.
- Undefined: the single sample at the mid tick is used.
- Delivery values and flags are otherwise identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK}.
  - localparams UART_DATA_BITS=8 and UART_OVERSAMPLE=16.
  - The same package is shared with the transmitter.
- Sub-module uart_sync: an N-stage reset-to-1 synchronizer, parameter STAGES. It is instantiated once for RxD.

Test Plan:
- enable every clk; drive frame 0xA5 (16 clk/bit) -> rx_data=0xA5, RDA=1, framing_error=0, busy=0 after delivery; read_ack -> RDA=0.
- RxD low for 6 ticks, then high -> no RDA, state returns to IDLE, busy=0; the next frame 0x3C is received correctly.
- Frame 0x3C with stop bit low, line held low 40 ticks, then high -> rx_data=0x3C, RDA=1, framing_error=1; no second byte while low; read_ack clears both flags.
- Frames 0x11 then 0x22 with no read_ack -> rx_data=0x22, RDA=1, overrun=1; read_ack clears all flags. Repeat with read_ack on the delivery cycle of 0x22 -> overrun=0, RDA=1.
- Assert reset after 3 data bits of 0xFF -> all outputs 0; the next full frame 0x5A gives rx_data=0x5A with no error flags.
- Both macro builds: inject a 1-tick glitch at the mid-bit of bit 4 of 0x00 -> RX_MAJORITY_VOTE_EN build gives 0x00; the plain build gives the flipped bit (0x08 when MSB_FIRST=1).
